// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end: the halt encoding, the
// instruction-fetch state enum, the default PC and instruction widths, and a
// saturating-increment helper used by the optional fetch performance counters.
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int FETCH_ADDR_W  = 5;
  localparam int FETCH_INSTR_W = 32;

  // Fetching this word stops the sequencer until the next reset.
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the fetch sequencer's bus traffic:
//   instruction memory : imem_addr (to memory), imem_instr (from memory,
//                        combinational read in the same cycle)
//   IF/ID slot         : if_valid, if_instr, if_pc (to decode), id_ready
//                        (from decode)
//   redirect           : redirect, redirect_pc (from the branch/jump unit)
// Modports:
//   master - the fetch sequencer
//   slave  - the environment (memory, decode, branch unit)
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int ADDR_W  = mips_pkg::FETCH_ADDR_W,
  parameter int INSTR_W = mips_pkg::FETCH_INSTR_W
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_instr, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_instr, id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_sequencer_pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
// ADDR_W-bit program counter. Priority: synchronous active-low reset, then
// load (redirect target), then increment (modulo 2^ADDR_W), else hold.
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   i_load       load i_load_pc at the next edge
//   i_load_pc    load value
//   i_inc        advance the PC by one word
//   o_pc         current PC
// ---------------------------------------------------------------------------
module pc_register #(
  parameter int ADDR_W = mips_pkg::FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // NOTE: reset is synchronous here -- it is an ordinary high-priority branch
  // inside a posedge-only always_ff, so clk must run for reset to take effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      // Natural wrap from the all-ones index back to 0.
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller: owns the PC, addresses the instruction memory,
// registers the fetched word into the IF/ID slot under a valid/ready
// handshake, applies branch/jump redirects and stops on the halt encoding
// (only reset leaves HALT).
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   start        leave IDLE and begin fetching from PC 0
//   bus          fetch_sequencer_if.master (imem, IF/ID slot, redirect)
//   halted       sequencer is in HALT
//   fetch_count  captures into the slot, saturating  (FETCH_PERF_CNT_EN)
//   stall_count  RUN cycles with a full slot and decode not ready,
//                saturating                          (FETCH_PERF_CNT_EN)
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
// ---------------------------------------------------------------------------
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  fetch_sequencer_if.master       bus,
  output logic                    halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]             fetch_count,
  output logic [15:0]             stall_count
`endif
);

  fetch_state_e       r_state;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic               r_halted;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_run;
  logic               w_advance;
  logic               w_is_halt;
  logic               w_capture;
  logic               w_stall;

  assign w_run     = (r_state == RUN);
  // The slot can take a new word when it is empty or being drained this cycle.
  assign w_advance = !r_if_valid || bus.id_ready;
  assign w_is_halt = (bus.imem_instr == INSTR_W'(HALT_INSTR));
  // Redirect wins over both capture and halt detection.
  assign w_capture = w_run && !bus.redirect && w_advance && !w_is_halt;
  assign w_stall   = w_run && r_if_valid && !bus.id_ready;

  pc_register #(.ADDR_W(ADDR_W)) u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_run && bus.redirect),
    .i_load_pc (bus.redirect_pc),
    .i_inc     (w_capture),
    .o_pc      (w_pc)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_halted   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) r_state <= RUN;
        end
        RUN: begin
          if (bus.redirect) begin
            r_if_valid <= 1'b0;               // flush the wrong-path word
          end else if (w_advance) begin
            if (w_is_halt) begin
              // The halt word is never delivered; a pending word still drains.
              r_state  <= HALT;
              r_halted <= 1'b1;
              if (bus.id_ready) r_if_valid <= 1'b0;
            end else begin
              r_if_instr <= bus.imem_instr;
              r_if_pc    <= w_pc;
              r_if_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          if (bus.id_ready) r_if_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_capture) r_fetch_count <= sat_inc16(r_fetch_count);
      if (w_stall)   r_stall_count <= sat_inc16(r_stall_count);
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`else
  // Stall detection only feeds the performance counters.
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
`endif

  assign bus.imem_addr = w_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;
  assign halted        = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: directed scenarios (straight-line
// fetch, stall, redirect while stalled, PC wrap, halt, reset mid-run) followed
// by randomized traffic, all compared every cycle against a behavioural model
// of the fetch rules. Define FETCH_PERF_CNT_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int          AW        = 5;
  localparam int          DEPTH     = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  logic start;
  logic halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_sequencer_if #(.ADDR_W(AW), .INSTR_W(32)) bus ();

  logic [31:0] mem [DEPTH];
  assign bus.imem_instr = mem[bus.imem_addr];

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .halted (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: where the sequencer is in its life, what the slot holds.
  bit          m_started;   // has left IDLE since the last reset
  bit          m_stopped;   // has seen the halt word
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ipc;
  int          m_fetches;
  int          m_stalls;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  // Drive one cycle's inputs (called at a falling edge), advance the model by
  // the fetch rules, let the DUT take the rising edge, then compare.
  task automatic step(input bit rst_v, input bit st, input bit rdy,
                      input bit rd, input int rpc);
    reset           = rst_v;
    start           = st;
    bus.id_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = AW'(rpc);

    if (!rst_v) begin
      m_started = 0; m_stopped = 0; m_pc = 0; m_valid = 0;
      m_instr = '0; m_ipc = 0; m_fetches = 0; m_stalls = 0;
    end else if (m_started && !m_stopped) begin
      if (m_valid && !rdy && m_stalls < 65535) m_stalls++;
      if (rd) begin
        m_pc    = rpc % DEPTH;
        m_valid = 0;
      end else if (!m_valid || rdy) begin
        if (mem[m_pc] == HALT_WORD) begin
          m_stopped = 1;
          if (rdy) m_valid = 0;
        end else begin
          m_instr = mem[m_pc];
          m_ipc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 1) % DEPTH;
          if (m_fetches < 65535) m_fetches++;
        end
      end
    end else if (m_stopped) begin
      if (rdy) m_valid = 0;
    end else if (st) begin
      m_started = 1;
    end

    @(posedge clk);
    #1;
    check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    check("if_valid",  32'(bus.if_valid),  32'(m_valid));
    check("if_instr",  bus.if_instr,       m_instr);
    check("if_pc",     32'(bus.if_pc),     32'(m_ipc));
    check("halted",    32'(halted),        32'(m_stopped));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 32'(fetch_count), 32'(m_fetches));
    check("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    fill_linear();
    @(negedge clk);

    // Reset values.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_addr",  32'(bus.imem_addr), 32'd0);

    // Straight-line fetch: RUN entry gives a bubble, then one word per cycle.
    step(1, 1, 1, 0, 0);
    check("start_bubble", 32'(bus.if_valid), 32'd0);
    step(1, 0, 1, 0, 0);
    check("first_pc",    32'(bus.if_pc), 32'd0);
    check("first_instr", bus.if_instr,   32'h1000_0000);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("third_pc", 32'(bus.if_pc), 32'd2);

    // Stall three cycles at if_pc=2.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("stall_pc",    32'(bus.if_pc),     32'd2);
    check("stall_instr", bus.if_instr,       32'h1000_0002);
    check("stall_addr",  32'(bus.imem_addr), 32'd3);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt3",  32'(stall_count),   32'd3);
`endif

    // Redirect while stalled: one bubble, then the target word.
    step(1, 0, 0, 1, 5);
    check("redir_flush", 32'(bus.if_valid),  32'd0);
    check("redir_addr",  32'(bus.imem_addr), 32'd5);
    step(1, 0, 1, 0, 0);
    check("redir_pc",    32'(bus.if_pc),     32'd5);

    // Wrap from the last word back to 0.
    step(1, 0, 1, 1, 31);
    step(1, 0, 1, 0, 0);
    check("wrap_pc31",  32'(bus.if_pc),     32'd31);
    check("wrap_addr0", 32'(bus.imem_addr), 32'd0);
    step(1, 0, 1, 0, 0);
    check("wrap_pc0",   32'(bus.if_pc),     32'd0);

    // Halt at word 3; slot 2 is held until decode takes it.
    step(0, 0, 0, 0, 0);
    mem[3] = HALT_WORD;
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    check("halt_hold_valid", 32'(bus.if_valid), 32'd1);
    step(1, 0, 1, 0, 0);
    check("halt_flag",  32'(halted),         32'd1);
    check("halt_drain", 32'(bus.if_valid),   32'd0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 7);
    check("halt_addr_frozen", 32'(bus.imem_addr), 32'd3);
    check("halt_sticky",      32'(halted),        32'd1);

    // Reset mid-run (with a redirect on the same edge) then restart.
    mem[3] = 32'h1000_0003;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    check("pre_reset_pc", 32'(bus.if_pc), 32'd4);
    step(0, 0, 1, 1, 9);
    check("mid_reset_addr",  32'(bus.imem_addr), 32'd0);
    check("mid_reset_valid", 32'(bus.if_valid),  32'd0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("restart_pc", 32'(bus.if_pc), 32'd0);

    // Randomized traffic with occasional halt words and resets.
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT_WORD : $urandom;
    for (int n = 0; n < 800; n++) begin
      bit rst_v;
      rst_v = ($urandom_range(0, 59) != 0);
      if (m_stopped && $urandom_range(0, 9) == 0) rst_v = 0;
      if (!rst_v && $urandom_range(0, 1) == 0)
        for (int i = 0; i < DEPTH; i++)
          mem[i] = ($urandom_range(0, 11) == 0) ? HALT_WORD : $urandom;
      step(rst_v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, DEPTH - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
